eight_reg_16bits: RTL and testbench

Register file of eight 16-bit general-purpose registers with one synchronous write port and two independent asynchronous read ports (A and B). It is the operand register bank of the multi-cycle 16-bit RISC datapath. The control unit drives the write side; the ALU operand paths consume the A and B read ports.

---
 rtl/eight_reg_16bits.sv | 71 +++++++
 tb/tb_eight_reg_16bits.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/eight_reg_16bits.sv
// -----------------------------------------------------------------------------
// eight_reg_16bits
//
// Operand register bank for the multi-cycle 16-bit RISC datapath: eight
// 16-bit general-purpose registers (R0..R7, all writable, R0 is not tied to
// zero) with one synchronous write port and two independent combinational
// read ports.
//
// Ports
//    clk           system clock, registers update on its rising edge
//    rst_n         asynchronous active-low reset, clears R0..R7
//    Write_enable  write strobe, sampled at the rising edge of clk
//    Write_addr    destination register index (0..7)
//    Write_data    value stored into R[Write_addr]
//    ReadA_addr    register index driven onto ReadA_data
//    ReadB_addr    register index driven onto ReadB_data
//    ReadA_data    R[ReadA_addr], combinational
//    ReadB_data    R[ReadB_addr], combinational
//
// Reads are taken straight from the register outputs with no write bypass, so
// a read of the register being written shows the old value until the edge.
// -----------------------------------------------------------------------------
module eight_reg_16bits (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Write_enable,
   input  logic [2:0]  Write_addr,
   input  logic [15:0] Write_data,
   input  logic [2:0]  ReadA_addr,
   input  logic [2:0]  ReadB_addr,
   output logic [15:0] ReadA_data,
   output logic [15:0] ReadB_data
);

   // Packed view of all eight registers, used only by the read muxes.
   logic [7:0][15:0] regs_flat;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_reg
         logic        sel;
         logic [15:0] reg_d;
         logic [15:0] reg_q;

         // Address decode is qualified by the strobe, so whatever sits on
         // Write_addr/Write_data while disabled cannot reach the register.
         assign sel = Write_enable && (Write_addr == 3'(gi));

         always_comb begin
            reg_d = reg_q;
            if (sel) begin
               reg_d = Write_data;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               reg_q <= 16'h0000;
            end else begin
               reg_q <= reg_d;
            end
         end

         assign regs_flat[gi] = reg_q;
      end
   endgenerate

   assign ReadA_data = regs_flat[ReadA_addr];
   assign ReadB_data = regs_flat[ReadB_addr];

endmodule

// File: tb/tb_eight_reg_16bits.sv
// -----------------------------------------------------------------------------
// tb_eight_reg_16bits
//
// Drives the register file one cycle at a time. For every cycle the driver
// works out, from a plain array model of R0..R7, what both read ports must
// show before the next edge and pushes that into a scoreboard queue; a
// separate monitor pops one entry per falling edge and compares it with the
// live outputs.
// -----------------------------------------------------------------------------
module tb_eight_reg_16bits;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Write_enable;
   logic [2:0]  Write_addr;
   logic [15:0] Write_data;
   logic [2:0]  ReadA_addr;
   logic [2:0]  ReadB_addr;
   logic [15:0] ReadA_data;
   logic [15:0] ReadB_data;

   eight_reg_16bits dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Write_enable (Write_enable),
      .Write_addr   (Write_addr),
      .Write_data   (Write_data),
      .ReadA_addr   (ReadA_addr),
      .ReadB_addr   (ReadB_addr),
      .ReadA_data   (ReadA_data),
      .ReadB_data   (ReadB_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] exp_a;
      logic [15:0] exp_b;
      logic [2:0]  addr_a;
      logic [2:0]  addr_b;
      string       tag;
   } sb_entry_t;

   sb_entry_t   sb_q[$];
   logic [15:0] model_mem [8];
   int          n_checks = 0;
   int          n_fails  = 0;

   // Monitor: one transaction per falling edge, independent of the driver.
   initial begin
      sb_entry_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (ReadA_data !== e.exp_a) begin
               n_fails++;
               $display("FAIL %s portA addr=%0d got=%h want=%h", e.tag, e.addr_a, ReadA_data, e.exp_a);
            end
            n_checks++;
            if (ReadB_data !== e.exp_b) begin
               n_fails++;
               $display("FAIL %s portB addr=%0d got=%h want=%h", e.tag, e.addr_b, ReadB_data, e.exp_b);
            end
            $display("%s: rA=%0d A=%h (want %h)  rB=%0d B=%h (want %h)",
                     e.tag, e.addr_a, ReadA_data, e.exp_a, e.addr_b, ReadB_data, e.exp_b);
         end
      end
   end

   // One cycle of stimulus, entered just after a rising edge. Reset state is
   // applied to the model immediately (it is asynchronous); the write only
   // lands in the model at the following rising edge.
   task automatic do_cycle(input logic rst, input logic we, input logic [2:0] wa,
                           input logic [15:0] wd, input logic [2:0] ra,
                           input logic [2:0] rb, input string tag);
      sb_entry_t e;
      rst_n        = rst;
      Write_enable = we;
      Write_addr   = wa;
      Write_data   = wd;
      ReadA_addr   = ra;
      ReadB_addr   = rb;
      if (!rst) begin
         for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
      end
      e.exp_a  = model_mem[ra];
      e.exp_b  = model_mem[rb];
      e.addr_a = ra;
      e.addr_b = rb;
      e.tag    = tag;
      sb_q.push_back(e);
      @(posedge clk);
      if (rst && we) model_mem[wa] = wd;
      #1;
   endtask

   logic [15:0] load_vals [8];

   initial begin
      int          wait_cycles;
      logic        r_rst;
      logic        r_we;
      load_vals = '{16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd,
                    16'heeee, 16'hffff, 16'h5555, 16'h6666};
      for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;

      rst_n        = 1'b0;
      Write_enable = 1'b0;
      Write_addr   = 3'd0;
      Write_data   = 16'h0000;
      ReadA_addr   = 3'd0;
      ReadB_addr   = 3'd0;
      @(posedge clk);
      #1;

      // Reset held: every address reads zero, enabled writes are ignored.
      for (int i = 0; i < 8; i++)
         do_cycle(1'b0, 1'b1, 3'(i), 16'(32'h9000 + i), 3'(i), 3'(7 - i), "reset_sweep");

      // Sequential load; port A watches the target (old value), B the last one.
      for (int i = 0; i < 8; i++)
         do_cycle(1'b1, 1'b1, 3'(i), load_vals[i], 3'(i), 3'((i + 7) % 8), "load");

      for (int i = 0; i < 8; i++)
         do_cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), "readback");

      // Disabled writes of zero must leave everything intact.
      for (int i = 0; i < 8; i++)
         do_cycle(1'b1, 1'b0, 3'(i), 16'h0000, 3'(i), 3'(i), "write_disabled");

      for (int i = 0; i < 8; i++)
         do_cycle(1'b1, 1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 3'(i), 3'((i + 3) % 8), "readback2");

      // Dual-port independence, then swap.
      do_cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, "dual_port");
      do_cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd2, "dual_swap");

      // Read-during-write on R3: old value before the edge, new after.
      do_cycle(1'b1, 1'b1, 3'd3, 16'h1234, 3'd3, 3'd3, "rdw_before");
      do_cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd2, "rdw_after");
      do_cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd2, "rdw_neighbours");

      // Reset asserted between edges while writes are enabled.
      do_cycle(1'b0, 1'b1, 3'd1, 16'hbeef, 3'd1, 3'd6, "midop_reset");
      for (int i = 0; i < 4; i++)
         do_cycle(1'b0, 1'b1, 3'(i), 16'hc0de, 3'(i), 3'(i + 4), "reset_hold");
      do_cycle(1'b1, 1'b1, 3'd6, 16'h4321, 3'd6, 3'd1, "release_write");
      do_cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd1, "post_release");

      // Randomized traffic with occasional reset pulses.
      for (int i = 0; i < 400; i++) begin
         r_rst = ($urandom_range(0, 39) != 0);
         r_we  = ($urandom_range(0, 2) != 0);
         do_cycle(r_rst, r_we, 3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "random");
      end

      // Bounded drain of the scoreboard.
      wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      @(posedge clk);
      if (sb_q.size() > 0) begin
         n_fails++;
         $display("FAIL scoreboard_drain pending=%0d want=0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
